// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_stall;
  // data port
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_stall;
  // unified memory port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // arbiter side
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_stall, dm_rdata, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  // pipeline and memory side
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_stall, dm_rdata, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a fixed-latency unified memory (option: FETCH_BUF_EN)
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        last_grant, last_grant_n;   // 0 = data, 1 = fetch

  logic              done_d, done_i;
  logic              if_want, grant_d, grant_i;
  logic              fb_hit;
  logic              mem_en_c, mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic [DATA_W-1:0] if_rdata_c, dm_rdata_c;
  logic              if_stall_c, dm_stall_c;

`ifdef FETCH_BUF_EN
  logic              fb_valid;
  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_data;

  // a buffered fetch is only served when no access is in flight
  assign fb_hit = (state == IDLE) & bus.if_req & fb_valid & (bus.if_addr == fb_addr);
`else
  assign fb_hit = 1'b0;
`endif

  // state, latency counter and fairness flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      last_grant <= last_grant_n;
    end
  end

  // arbitration, issue, completion detection and output drive
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    last_grant_n = last_grant;
    done_d       = 1'b0;
    done_i       = 1'b0;
    if_want      = 1'b0;
    grant_d      = 1'b0;
    grant_i      = 1'b0;
    mem_en_c     = 1'b0;
    mem_we_c     = 1'b0;
    mem_addr_c   = '0;
    mem_wdata_c  = '0;
    if_rdata_c   = '0;
    dm_rdata_c   = '0;
    if_stall_c   = 1'b0;
    dm_stall_c   = 1'b0;

    case (state)
      IDLE: begin
        // a buffer hit takes the fetch out of arbitration entirely
        if_want = bus.if_req & ~fb_hit;
        // on contention data wins unless data was served last
        grant_d = bus.dm_req & (~if_want | last_grant);
        grant_i = if_want & ~grant_d;
        if (grant_d) begin
          mem_en_c     = 1'b1;
          mem_we_c     = bus.dm_we;
          mem_addr_c   = bus.dm_addr;
          mem_wdata_c  = bus.dm_wdata;
          state_n      = BUSY_D;
          cnt_n        = 4'd1;
          last_grant_n = 1'b0;
        end else if (grant_i) begin
          mem_en_c     = 1'b1;
          mem_addr_c   = bus.if_addr;
          state_n      = BUSY_I;
          cnt_n        = 4'd1;
          last_grant_n = 1'b1;
        end
      end
      BUSY_D, BUSY_I: begin
        cnt_n = cnt + 4'd1;
        if (cnt == LAT) begin
          done_d  = (state == BUSY_D);
          done_i  = (state == BUSY_I);
          state_n = IDLE;
          cnt_n   = 4'd0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end
    endcase

    if (done_d) dm_rdata_c = bus.mem_rdata;
    if (done_i) if_rdata_c = bus.mem_rdata;
`ifdef FETCH_BUF_EN
    if (fb_hit) if_rdata_c = fb_data;
`endif

    dm_stall_c = bus.dm_req & ~done_d;
    if_stall_c = bus.if_req & ~done_i & ~fb_hit;

    // reset is asynchronous, so outputs are forced quiet while it is held
    if (!reset) begin
      mem_en_c    = 1'b0;
      mem_we_c    = 1'b0;
      mem_addr_c  = '0;
      mem_wdata_c = '0;
      if_rdata_c  = '0;
      dm_rdata_c  = '0;
      if_stall_c  = 1'b0;
      dm_stall_c  = 1'b0;
    end
  end

`ifdef FETCH_BUF_EN
  // fetch buffer: filled on fetch completion, invalidated by a store to its address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fb_valid <= 1'b0;
      fb_addr  <= '0;
      fb_data  <= '0;
    end else if (done_i) begin
      fb_valid <= 1'b1;
      fb_addr  <= bus.if_addr;
      fb_data  <= bus.mem_rdata;
    end else if (mem_en_c & mem_we_c & (mem_addr_c == fb_addr)) begin
      fb_valid <= 1'b0;
    end
  end
`endif

  assign bus.mem_en    = mem_en_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.if_rdata  = if_rdata_c;
  assign bus.dm_rdata  = dm_rdata_c;
  assign bus.if_stall  = if_stall_c;
  assign bus.dm_stall  = dm_stall_c;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int MEM_LAT = 2;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // fixed-latency memory model: data appears exactly MEM_LAT cycles after issue
  logic [31:0] mem [0:255];
  logic        pend_act;
  logic [7:0]  pend_cnt;
  logic [31:0] pend_addr;

  function automatic logic [31:0] mem_init(input int i);
    if (i == 16)      return 32'h8C010004;
    else if (i == 64) return 32'h12345678;
    else              return 32'hA5000000 | i;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= mem_init(i);
      pend_act  <= 1'b0;
      pend_cnt  <= 8'd0;
      pend_addr <= 32'd0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      pend_act  <= 1'b1;
      pend_cnt  <= 8'd1;
      pend_addr <= bus.mem_addr;
    end else if (pend_act) begin
      if (pend_cnt == 8'(MEM_LAT)) pend_act <= 1'b0;
      else                         pend_cnt <= pend_cnt + 8'd1;
    end
  end

  assign bus.mem_rdata = (pend_act && pend_cnt == 8'(MEM_LAT)) ? mem[pend_addr[9:2]] : 32'hBAD0BAD0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_if(input logic req, input logic [31:0] addr);
    bus.if_req  = req;
    bus.if_addr = addr;
  endtask

  task automatic set_dm(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.dm_req   = req;
    bus.dm_we    = we;
    bus.dm_addr  = addr;
    bus.dm_wdata = wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b0;
    set_if(1'b0, 32'h0);
    set_dm(1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    // requests held during reset must not produce any activity
    set_if(1'b1, 32'h40);
    set_dm(1'b1, 1'b0, 32'h100, 32'h0);
    @(negedge clk);
    chk("rst_mem_en",    32'(bus.mem_en),   32'd0);
    chk("rst_mem_we",    32'(bus.mem_we),   32'd0);
    chk("rst_if_stall",  32'(bus.if_stall), 32'd0);
    chk("rst_dm_stall",  32'(bus.dm_stall), 32'd0);
    chk("rst_if_rdata",  bus.if_rdata,      32'd0);
    chk("rst_dm_rdata",  bus.dm_rdata,      32'd0);
    chk("rst_mem_addr",  bus.mem_addr,      32'd0);
    chk("rst_mem_wdata", bus.mem_wdata,     32'd0);
    set_if(1'b0, 32'h0);
    set_dm(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    reset = 1'b1;

    // fetch only
    set_if(1'b1, 32'h40);
    @(negedge clk);
    chk("t1_c0_mem_en",   32'(bus.mem_en),   32'd1);
    chk("t1_c0_mem_addr", bus.mem_addr,      32'h40);
    chk("t1_c0_mem_we",   32'(bus.mem_we),   32'd0);
    chk("t1_c0_if_stall", 32'(bus.if_stall), 32'd1);
    tick();
    @(negedge clk);
    chk("t1_c1_mem_en",   32'(bus.mem_en),   32'd0);
    chk("t1_c1_if_stall", 32'(bus.if_stall), 32'd1);
    tick();
    @(negedge clk);
    chk("t1_c2_if_stall", 32'(bus.if_stall), 32'd0);
    chk("t1_c2_if_rdata", bus.if_rdata,      32'h8C010004);
    tick();
    set_if(1'b0, 32'h0);
    @(negedge clk);
    chk("t1_c3_mem_en",   32'(bus.mem_en),   32'd0);
    chk("t1_c3_if_stall", 32'(bus.if_stall), 32'd0);
    tick();

    // simultaneous fetch and load right after reset: data first
    reset = 1'b0;
    tick();
    reset = 1'b1;
    set_if(1'b1, 32'h40);
    set_dm(1'b1, 1'b0, 32'h100, 32'h0);
    @(negedge clk);
    chk("t2_c0_mem_en",   32'(bus.mem_en),   32'd1);
    chk("t2_c0_mem_addr", bus.mem_addr,      32'h100);
    chk("t2_c0_dm_stall", 32'(bus.dm_stall), 32'd1);
    chk("t2_c0_if_stall", 32'(bus.if_stall), 32'd1);
    tick();
    @(negedge clk);
    chk("t2_c1_dm_stall", 32'(bus.dm_stall), 32'd1);
    chk("t2_c1_if_stall", 32'(bus.if_stall), 32'd1);
    tick();
    @(negedge clk);
    chk("t2_c2_dm_stall", 32'(bus.dm_stall), 32'd0);
    chk("t2_c2_dm_rdata", bus.dm_rdata,      32'h12345678);
    chk("t2_c2_if_stall", 32'(bus.if_stall), 32'd1);
    tick();
    set_dm(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t2_c3_mem_en",   32'(bus.mem_en),   32'd1);
    chk("t2_c3_mem_addr", bus.mem_addr,      32'h40);
    chk("t2_c3_if_stall", 32'(bus.if_stall), 32'd1);
    tick();
    @(negedge clk);
    chk("t2_c4_if_stall", 32'(bus.if_stall), 32'd1);
    tick();
    @(negedge clk);
    chk("t2_c5_if_stall", 32'(bus.if_stall), 32'd0);
    chk("t2_c5_if_rdata", bus.if_rdata,      32'h8C010004);
    tick();
    set_if(1'b0, 32'h0);

    // back-to-back contention: grants alternate D,I,D,I
    set_if(1'b1, 32'h48);
    set_dm(1'b1, 1'b0, 32'h100, 32'h0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("t3_c%0d_mem_en", c), 32'(bus.mem_en), (c % 3 == 0) ? 32'd1 : 32'd0);
      if (c % 3 == 0)
        chk($sformatf("t3_c%0d_mem_addr", c), bus.mem_addr,
            (c == 0 || c == 6) ? 32'h100 : ((c == 3) ? 32'h48 : 32'h4C));
      chk($sformatf("t3_c%0d_dm_stall", c), 32'(bus.dm_stall), (c == 2 || c == 8) ? 32'd0 : 32'd1);
      chk($sformatf("t3_c%0d_if_stall", c), 32'(bus.if_stall), (c == 5 || c == 11) ? 32'd0 : 32'd1);
      tick();
      if (c == 5) bus.if_addr = 32'h4C;
    end
    set_if(1'b0, 32'h0);
    set_dm(1'b0, 1'b0, 32'h0, 32'h0);

    // store, then read it back
    set_dm(1'b1, 1'b1, 32'h200, 32'hDEADBEEF);
    @(negedge clk);
    chk("t4_c0_mem_en",    32'(bus.mem_en),   32'd1);
    chk("t4_c0_mem_we",    32'(bus.mem_we),   32'd1);
    chk("t4_c0_mem_addr",  bus.mem_addr,      32'h200);
    chk("t4_c0_mem_wdata", bus.mem_wdata,     32'hDEADBEEF);
    chk("t4_c0_dm_stall",  32'(bus.dm_stall), 32'd1);
    tick();
    @(negedge clk);
    chk("t4_c1_mem_en",   32'(bus.mem_en),   32'd0);
    chk("t4_c1_mem_we",   32'(bus.mem_we),   32'd0);
    chk("t4_c1_dm_stall", 32'(bus.dm_stall), 32'd1);
    tick();
    @(negedge clk);
    chk("t4_c2_dm_stall", 32'(bus.dm_stall), 32'd0);
    tick();
    set_dm(1'b1, 1'b0, 32'h200, 32'h0);
    @(negedge clk);
    chk("t4_ld_mem_we", 32'(bus.mem_we), 32'd0);
    tick();
    tick();
    @(negedge clk);
    chk("t4_ld_dm_stall", 32'(bus.dm_stall), 32'd0);
    chk("t4_ld_dm_rdata", bus.dm_rdata,      32'hDEADBEEF);
    tick();
    set_dm(1'b0, 1'b0, 32'h0, 32'h0);

    // reset in BUSY_I with cnt=1, fetch held across it
    set_if(1'b1, 32'h40);
    @(negedge clk);
    chk("t5_c0_mem_en", 32'(bus.mem_en), 32'd1);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t5_rst_mem_en",   32'(bus.mem_en),   32'd0);
    chk("t5_rst_if_stall", 32'(bus.if_stall), 32'd0);
    chk("t5_rst_if_rdata", bus.if_rdata,      32'd0);
    chk("t5_rst_mem_addr", bus.mem_addr,      32'd0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("t5_r0_mem_en",   32'(bus.mem_en),   32'd1);
    chk("t5_r0_mem_addr", bus.mem_addr,      32'h40);
    chk("t5_r0_if_stall", 32'(bus.if_stall), 32'd1);
    tick();
    @(negedge clk);
    chk("t5_r1_if_stall", 32'(bus.if_stall), 32'd1);
    tick();
    @(negedge clk);
    chk("t5_r2_if_stall", 32'(bus.if_stall), 32'd0);
    chk("t5_r2_if_rdata", bus.if_rdata,      32'h8C010004);
    tick();

    // second fetch of the same address
`ifdef FETCH_BUF_EN
    @(negedge clk);
    chk("t6_hit_mem_en",   32'(bus.mem_en),   32'd0);
    chk("t6_hit_if_stall", 32'(bus.if_stall), 32'd0);
    chk("t6_hit_if_rdata", bus.if_rdata,      32'h8C010004);
    tick();
`else
    @(negedge clk);
    chk("t6_rep_mem_en",   32'(bus.mem_en),   32'd1);
    chk("t6_rep_if_stall", 32'(bus.if_stall), 32'd1);
    tick();
    tick();
    @(negedge clk);
    chk("t6_rep_done_stall", 32'(bus.if_stall), 32'd0);
    chk("t6_rep_if_rdata",   bus.if_rdata,      32'h8C010004);
    tick();
`endif
    set_if(1'b0, 32'h0);

    // store to the fetched address, then fetch it again from memory
    set_dm(1'b1, 1'b1, 32'h40, 32'h11112222);
    @(negedge clk);
    chk("t6_st_mem_en", 32'(bus.mem_en), 32'd1);
    tick();
    tick();
    @(negedge clk);
    chk("t6_st_dm_stall", 32'(bus.dm_stall), 32'd0);
    tick();
    set_dm(1'b0, 1'b0, 32'h0, 32'h0);
    set_if(1'b1, 32'h40);
    @(negedge clk);
    chk("t6_rf_mem_en",   32'(bus.mem_en),   32'd1);
    chk("t6_rf_if_stall", 32'(bus.if_stall), 32'd1);
    tick();
    tick();
    @(negedge clk);
    chk("t6_rf_done_stall", 32'(bus.if_stall), 32'd0);
    chk("t6_rf_if_rdata",   bus.if_rdata,      32'h11112222);
    tick();
    set_if(1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
